// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: streams packed instructions from DDR into a
// first-word-fall-through FIFO feeding the top controller.
module inst_fetch_queue #(
    parameter int INST_LEN     = 220,
    parameter int BEAT_W       = 64,
    parameter int DEPTH        = 16,
    parameter int DDR_ADDR_LEN = 32,
    parameter int CNT_LEN      = 16,
    parameter int MAX_OUTST    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DDR_ADDR_LEN-1:0] base_addr,
    input  logic [CNT_LEN-1:0]      inst_num,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_req,
    output logic [DDR_ADDR_LEN-1:0] mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [BEAT_W-1:0]       mem_rdata,
    output logic [INST_LEN-1:0]     instruct,
    output logic                    inst_empty,
    input  logic                    inst_req,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int BEATS = (INST_LEN + BEAT_W - 1) / BEAT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int OW    = $clog2(MAX_OUTST + 1);
    localparam logic [DDR_ADDR_LEN-1:0] STEP  = DDR_ADDR_LEN'(BEAT_W / 8);
    localparam logic [CW:0]             DEP_C = (CW + 1)'(DEPTH);
    localparam logic [OW-1:0]           MAX_C = OW'(MAX_OUTST);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t                  state;
    logic [DDR_ADDR_LEN-1:0] nxt_addr;
    logic [CNT_LEN-1:0]      iss_left;
    logic [CNT_LEN-1:0]      push_left;
    logic [BW-1:0]           iss_beat;
    logic [BW-1:0]           rx_beat;
    logic [OW-1:0]           outst;
    logic [OW-1:0]           outst_n;
    logic [CW-1:0]           reserved;
    logic [CW-1:0]           res_base;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_n;
    logic [CW:0]             occ;
    logic [INST_LEN-1:0]     asm_buf;
    logic                    push_pend;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [INST_LEN-1:0]     fifo_mem [DEPTH];

    logic issue;
    logic ret;
    logic pop;
    logic first;
    logic last_iss;
    logic last_rx;
    logic raise;

    assign issue    = mem_req && mem_gnt;
    assign ret      = mem_rvalid && (outst != '0);
    assign pop      = inst_req && (cnt != '0);
    assign cnt_n    = cnt + CW'(push_pend) - CW'(pop);
    assign outst_n  = outst + OW'(issue) - OW'(ret);
    assign res_base = reserved - CW'(push_pend);
    assign occ      = {1'b0, cnt_n} + {1'b0, res_base};
    assign first    = (iss_beat == '0);
    assign last_iss = (iss_beat == BW'(BEATS - 1));
    assign last_rx  = (rx_beat == BW'(BEATS - 1));

    // Next beat is raised only if it can be granted without breaking
    // the outstanding limit or the FIFO slot reservation.
    assign raise = (state == FETCH)
                && (iss_left != '0)
                && (!mem_req || mem_gnt)
                && (outst_n < MAX_C)
                && (!first || (occ < DEP_C));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            nxt_addr  <= '0;
            iss_left  <= '0;
            push_left <= '0;
            iss_beat  <= '0;
            rx_beat   <= '0;
            outst     <= '0;
            reserved  <= '0;
            push_pend <= 1'b0;
        end else begin
            done      <= 1'b0;
            outst     <= outst_n;
            reserved  <= res_base + CW'(raise && first);
            mem_req   <= raise || (mem_req && !mem_gnt);
            push_pend <= ret && last_rx;

            if (raise) begin
                mem_addr <= nxt_addr;
                nxt_addr <= nxt_addr + STEP;
                if (last_iss) begin
                    iss_beat <= '0;
                    iss_left <= iss_left - CNT_LEN'(1);
                end else begin
                    iss_beat <= iss_beat + BW'(1);
                end
            end

            if (ret) begin
                rx_beat <= last_rx ? '0 : rx_beat + BW'(1);
            end

            if (push_pend) begin
                push_left <= push_left - CNT_LEN'(1);
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (inst_num == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            busy      <= 1'b1;
                            iss_left  <= inst_num;
                            push_left <= inst_num;
                            nxt_addr  <= base_addr;
                            iss_beat  <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (iss_left == '0 && !(mem_req && !mem_gnt)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE && push_pend && push_left == CNT_LEN'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

    // The final beat may be partial; bits past INST_LEN are dropped.
    for (genvar j = 0; j < BEATS; j++) begin : g_beat
        localparam int LO = j * BEAT_W;
        localparam int W  = (INST_LEN - LO < BEAT_W) ? INST_LEN - LO : BEAT_W;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                asm_buf[LO +: W] <= '0;
            end else if (ret && rx_beat == BW'(j)) begin
                asm_buf[LO +: W] <= mem_rdata[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_pend) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push_pend) begin
            fifo_mem[wr_ptr] <= asm_buf;
        end
    end

    assign inst_empty = (cnt == '0);
    assign instruct   = inst_empty ? '0 : fifo_mem[rd_ptr];
    assign fifo_count = cnt;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: memory model, consumer monitor
// and directed programs covering flow control, wrap and reset.
module tb_inst_fetch_queue;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [15:0]   inst_num = '0;
    logic          busy;
    logic          done;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [63:0]   mem_rdata = '0;
    logic [219:0]  instruct;
    logic          inst_empty;
    logic          inst_req = 1'b0;
    logic [4:0]    fifo_count;

    inst_fetch_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .inst_num   (inst_num),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .instruct   (instruct),
        .inst_empty (inst_empty),
        .inst_req   (inst_req),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_of(logic [31:0] a);
        return {a ^ 32'hA5A5_0F0F, a + 32'h1357_9BDF};
    endfunction

    function automatic logic [219:0] word_of(logic [31:0] b, int i);
        logic [255:0] w;
        for (int j = 0; j < 4; j++)
            w[j*64 +: 64] = beat_of(b + 32'(i * 32) + 32'(j * 8));
        return w[219:0];
    endfunction

    typedef struct {
        logic [31:0] a;
        int          t;
    } pend_t;

    logic [219:0] exp_q[$];
    logic [31:0]  addr_q[$];
    pend_t        pend_q[$];

    int   gnt_pct = 100;
    int   lat_min = 2;
    int   lat_max = 2;
    int   n_gnt = 0;
    int   max_out = 0;
    int   ret_cnt = 0;
    int   last_rv_cyc = -10;
    int   req_seen = 0;
    logic prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    int   pop_mode = 1;
    int   pop_budget = 0;
    int   done_cnt = 0;
    logic cnt_chk = 1'b0;

    // memory model: grants, in-order returns, address and hold checks
    initial begin
        pend_t p;
        int    t;
        forever begin
            @(negedge clk);
            if (prev_wait && rst_n) begin
                check("req_hold", mem_req, 1);
                check("addr_hold", mem_addr, prev_addr);
            end
            if (mem_req) req_seen++;
            mem_rvalid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].t <= cyc) begin
                p = pend_q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata = beat_of(p.a);
                if (ret_cnt % 4 == 3) last_rv_cyc = cyc;
                ret_cnt++;
            end
            mem_gnt = ($urandom_range(99) < gnt_pct);
            prev_wait = mem_req && !mem_gnt;
            prev_addr = mem_addr;
            if (mem_req && mem_gnt && rst_n) begin
                n_gnt++;
                t = cyc + $urandom_range(lat_max, lat_min);
                if (pend_q.size() > 0 && t <= pend_q[pend_q.size()-1].t)
                    t = pend_q[pend_q.size()-1].t + 1;
                p.a = mem_addr;
                p.t = t;
                pend_q.push_back(p);
                check("addr_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0)
                    check("mem_addr", mem_addr, addr_q.pop_front());
                if (pend_q.size() > max_out) max_out = pend_q.size();
            end
        end
    end

    // consumer monitor: pops and compares against the scoreboard
    initial begin
        logic do_pop;
        forever begin
            @(negedge clk);
            inst_req = 1'b0;
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
            end
            if (cnt_chk) begin
                cnt_chk = 1'b0;
                check("cnt_push_pop", fifo_count, 1);
            end
            if (rst_n && !inst_empty) begin
                do_pop = (pop_mode == 1)
                      || (pop_mode == 2 && cyc == last_rv_cyc + 1)
                      || (pop_mode == 3 && pop_budget > 0);
                if (do_pop) begin
                    if (pop_mode == 3) pop_budget--;
                    if (pop_mode == 2) cnt_chk = 1'b1;
                    check("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0)
                        check("instruct", instruct, exp_q.pop_front());
                    inst_req = 1'b1;
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic run(logic [31:0] b, int num);
        for (int i = 0; i < num; i++) begin
            exp_q.push_back(word_of(b, i));
            for (int j = 0; j < 4; j++)
                addr_q.push_back(b + 32'(i * 32) + 32'(j * 8));
        end
        base_addr = b;
        inst_num = 16'(num);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(int d0, int lim, string name);
        int k = 0;
        while (done_cnt == d0 && k < lim) begin
            tick(1);
            k++;
        end
        check({name, "_done"}, done_cnt != d0, 1);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_empty"}, inst_empty, 1);
        check({tag, "_instruct"}, instruct, 0);
        check({tag, "_count"}, fifo_count, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int g0;
        int r0;
        int k;

        rst_n = 1'b0;
        tick(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick(1);

        // basic program, three instructions
        d0 = done_cnt;
        g0 = n_gnt;
        run(32'h1000, 3);
        wait_done(d0, 300, "t1");
        tick(10);
        check("t1_done_once", done_cnt, d0 + 1);
        check("t1_grants", n_gnt - g0, 12);
        check("t1_drained", exp_q.size(), 0);
        check("t1_busy", busy, 0);

        // fill to the reservation limit, then release four slots
        pop_mode = 0;
        d0 = done_cnt;
        g0 = n_gnt;
        run(32'h4000, 20);
        k = 0;
        while (fifo_count != 5'd16 && k < 500) begin
            tick(1);
            k++;
        end
        tick(50);
        check("t2_full", fifo_count, 16);
        check("t2_stall_grants", n_gnt - g0, 64);
        check("t2_busy", busy, 1);
        pop_budget = 4;
        pop_mode = 3;
        wait_done(d0, 500, "t2");
        tick(5);
        check("t2_grants", n_gnt - g0, 80);
        check("t2_refill", fifo_count, 16);
        pop_mode = 1;
        k = 0;
        while (!inst_empty && k < 100) begin
            tick(1);
            k++;
        end
        check("t2_drained", exp_q.size(), 0);

        // random grant and latency, address wrap at 2^32
        gnt_pct = 30;
        lat_min = 1;
        lat_max = 10;
        max_out = 0;
        d0 = done_cnt;
        run(32'hFFFF_FF80, 6);
        wait_done(d0, 3000, "t3");
        tick(20);
        check("t3_outst_le8", max_out <= 8, 1);
        check("t3_drained", exp_q.size(), 0);

        // long fixed latency drives outstanding to its ceiling
        gnt_pct = 100;
        lat_min = 12;
        lat_max = 12;
        max_out = 0;
        d0 = done_cnt;
        run(32'h0000_A000, 4);
        wait_done(d0, 500, "t3b");
        tick(20);
        check("t3b_outst_max", max_out, 8);
        check("t3b_drained", exp_q.size(), 0);

        // push and pop in the same cycle with one word stored
        lat_min = 2;
        lat_max = 2;
        ret_cnt = 0;
        pop_mode = 2;
        d0 = done_cnt;
        run(32'h5000, 2);
        wait_done(d0, 200, "t4");
        tick(5);
        check("t4_count", fifo_count, 1);
        pop_mode = 1;
        tick(5);
        check("t4_drained", exp_q.size(), 0);
        check("t4_empty", inst_empty, 1);

        // zero-length program and start while busy
        d0 = done_cnt;
        g0 = n_gnt;
        r0 = req_seen;
        run(32'h6000, 0);
        check("t5_done_pulse", done, 1);
        tick(1);
        check("t5_done_low", done, 0);
        tick(5);
        check("t5_no_req", req_seen - r0, 0);
        check("t5_busy", busy, 0);
        d0 = done_cnt;
        run(32'h7000, 2);
        base_addr = 32'h9000;
        inst_num = 16'd3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t5_busy_during", busy, 1);
        wait_done(d0, 200, "t5");
        tick(10);
        check("t5_grants", n_gnt - g0, 8);
        check("t5_drained", exp_q.size(), 0);
        check("t5_done_once", done_cnt, d0 + 1);

        // reset mid-drain with beats in flight
        lat_min = 12;
        lat_max = 12;
        g0 = n_gnt;
        run(32'h2000, 4);
        k = 0;
        while (n_gnt - g0 < 16 && k < 300) begin
            tick(1);
            k++;
        end
        tick(2);
        check("t6_inflight", pend_q.size() > 0, 1);
        rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        tick(1);
        check_reset_vals("t6_rst");
        tick(1);
        rst_n = 1'b1;
        k = 0;
        while (pend_q.size() != 0 && k < 100) begin
            tick(1);
            k++;
        end
        tick(3);
        check("t6_late_empty", inst_empty, 1);
        check("t6_late_count", fifo_count, 0);
        check("t6_idle", busy, 0);
        lat_min = 2;
        lat_max = 2;
        ret_cnt = 0;
        d0 = done_cnt;
        g0 = n_gnt;
        run(32'h3000, 2);
        wait_done(d0, 200, "t6");
        tick(10);
        check("t6_grants", n_gnt - g0, 8);
        check("t6_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
